// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter that serialises pixel writes from NUM_SRC object datapaths
// through a FIFO onto the VGA adapter port. Define CLIP_EN to drop off-screen pixels.
module pixel_write_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int X_W        = 7,
   parameter int Y_W        = 7,
   parameter int C_W        = 3,
   parameter int X_MAX      = 127,
   parameter int Y_MAX      = 119
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          flush,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC*X_W-1:0]        src_x,
   input  logic [NUM_SRC*Y_W-1:0]        src_y,
   input  logic [NUM_SRC*C_W-1:0]        src_colour,
   output logic [NUM_SRC-1:0]            src_ready,
   input  logic                          out_ready,
   output logic [X_W-1:0]                vga_x,
   output logic [Y_W-1:0]                vga_y,
   output logic [C_W-1:0]                vga_colour,
   output logic                          vga_plot,
   output logic [$clog2(FIFO_DEPTH):0]   fill,
   output logic [7:0]                    clip_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = $clog2(NUM_SRC);
   localparam logic [AW:0]    DEPTH_L = (AW+1)'(FIFO_DEPTH);
   localparam logic [X_W-1:0] X_LIM   = X_W'(X_MAX);
   localparam logic [Y_W-1:0] Y_LIM   = Y_W'(Y_MAX);
   localparam logic [PW-1:0]  LAST    = PW'(NUM_SRC - 1);

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [C_W-1:0] c;
   } pixel_t;

   pixel_t          mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [PW-1:0]   rr_ptr;

   logic            found;
   logic [PW-1:0]   grant_idx;
   pixel_t          grant_pix;
   logic            can_accept, accept, clipped, push, pop, out_of_range;
   pixel_t          head;

   // Scan sources starting at the round-robin pointer; first valid one wins.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      grant_pix = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         int idx;
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (!found && src_valid[idx]) begin
            found       = 1'b1;
            grant_idx   = PW'(idx);
            grant_pix.x = src_x[idx*X_W +: X_W];
            grant_pix.y = src_y[idx*Y_W +: Y_W];
            grant_pix.c = src_colour[idx*C_W +: C_W];
         end
      end
   end

   // Readiness deliberately ignores out_ready so a full FIFO never accepts.
   assign can_accept   = reset_n && !flush && (fill < DEPTH_L);
   assign accept       = found && can_accept;
   assign out_of_range = (grant_pix.x > X_LIM) || (grant_pix.y > Y_LIM);
   assign pop          = vga_plot && out_ready && !flush;
   assign push         = accept && !clipped;

   always_comb begin
      src_ready = '0;
      if (accept) src_ready[grant_idx] = 1'b1;
   end

`ifdef CLIP_EN
   assign clipped = out_of_range;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         clip_count <= '0;
      else if (accept && clipped && clip_count != 8'hFF)
         clip_count <= clip_count + 8'd1;
   end
`else
   logic unused_clip;
   assign unused_clip = out_of_range;
   assign clipped     = 1'b0;
   assign clip_count  = '0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         rr_ptr <= '0;
         fill   <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         rr_ptr <= '0;
         fill   <= '0;
      end else begin
         if (accept) rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // NOTE: the storage array has no reset; fill/pointers alone define which
   // entries are meaningful, and empty-state outputs are forced to zero below.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= grant_pix;
   end

   assign head       = mem[rd_ptr];
   assign vga_plot   = (fill != '0);
   assign vga_x      = vga_plot ? head.x : '0;
   assign vga_y      = vga_plot ? head.y : '0;
   assign vga_colour = vga_plot ? head.c : '0;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter: vector table plus hand sequences for
// full, flush, async reset and clipping (CLIP_EN-aware).
module tb_pixel_write_arbiter;

   logic        clk = 1'b0;
   logic        reset_n, flush, out_ready;
   logic [3:0]  src_valid, src_ready;
   logic [27:0] src_x, src_y;
   logic [11:0] src_colour;
   logic [6:0]  vga_x, vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic [3:0]  fill;
   logic [7:0]  clip_count;

   int checks   = 0;
   int failures = 0;

   localparam logic [27:0] DX = {7'd13, 7'd12, 7'd11, 7'd10};
   localparam logic [27:0] DY = {7'd23, 7'd22, 7'd21, 7'd20};
   localparam logic [11:0] DC = {3'd4, 3'd3, 3'd2, 3'd1};

   pixel_write_arbiter dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .src_valid  (src_valid),
      .src_x      (src_x),
      .src_y      (src_y),
      .src_colour (src_colour),
      .src_ready  (src_ready),
      .out_ready  (out_ready),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .fill       (fill),
      .clip_count (clip_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [27:0] sx, sy;
      logic [11:0] sc;
      logic        ordy;
      logic [3:0]  e_ready;
      logic        e_plot;
      logic [6:0]  e_x, e_y;
      logic [2:0]  e_c;
      logic [3:0]  e_fill;
   } vec_t;

   vec_t v [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic [3:0] val, input logic [27:0] sx,
                        input logic [27:0] sy, input logic [11:0] sc, input logic ordy);
      flush = fl; src_valid = val; src_x = sx; src_y = sy; src_colour = sc; out_ready = ordy;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [3:0] val, input logic ordy, input logic [3:0] er,
                               input logic ep, input logic [6:0] ex, input logic [6:0] ey,
                               input logic [2:0] ec, input logic [3:0] ef);
      vec_t r;
      r.valid = val; r.sx = DX; r.sy = DY; r.sc = DC; r.ordy = ordy;
      r.e_ready = er; r.e_plot = ep; r.e_x = ex; r.e_y = ey; r.e_c = ec; r.e_fill = ef;
      return r;
   endfunction

   initial begin
      // Round-robin from reset (pointer 0), one pop per cycle keeps fill at 1.
      v[0]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 7'd10, 7'd20, 3'd1, 4'd1);
      v[1]  = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 7'd11, 7'd21, 3'd2, 4'd1);
      v[2]  = mk(4'b1111, 1'b1, 4'b0100, 1'b1, 7'd12, 7'd22, 3'd3, 4'd1);
      v[3]  = mk(4'b1111, 1'b1, 4'b1000, 1'b1, 7'd13, 7'd23, 3'd4, 4'd1);
      v[4]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 7'd10, 7'd20, 3'd1, 4'd1);
      v[5]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 7'd0,  7'd0,  3'd0, 4'd0);
      // Single pixel x=5,y=9,c=3 from source 0.
      v[6]  = mk(4'b0001, 1'b0, 4'b0001, 1'b1, 7'd5,  7'd9,  3'd3, 4'd1);
      v[6].sx = {7'd13, 7'd12, 7'd11, 7'd5};
      v[6].sy = {7'd23, 7'd22, 7'd21, 7'd9};
      v[6].sc = {3'd4, 3'd3, 3'd2, 3'd3};
      v[7]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 7'd0,  7'd0,  3'd0, 4'd0);
      // Sparse requesters 1 and 3, pointer starting at 1.
      v[8]  = mk(4'b1010, 1'b0, 4'b0010, 1'b1, 7'd11, 7'd21, 3'd2, 4'd1);
      v[9]  = mk(4'b1010, 1'b0, 4'b1000, 1'b1, 7'd11, 7'd21, 3'd2, 4'd2);
      v[10] = mk(4'b1010, 1'b0, 4'b0010, 1'b1, 7'd11, 7'd21, 3'd2, 4'd3);
      v[11] = mk(4'b0000, 1'b1, 4'b0000, 1'b1, 7'd13, 7'd23, 3'd4, 4'd2);
      v[12] = mk(4'b0000, 1'b1, 4'b0000, 1'b1, 7'd11, 7'd21, 3'd2, 4'd1);
      v[13] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 7'd0,  7'd0,  3'd0, 4'd0);

      reset_n = 1'b0;
      drive(1'b0, 4'b1111, DX, DY, DC, 1'b0);
      #1;
      check("reset_ready", src_ready, 4'b0000);
      check("reset_plot", vga_plot, 1'b0);
      check("reset_fill", fill, 4'd0);
      check("reset_x", vga_x, 7'd0);
      check("reset_clip", clip_count, 8'd0);
      tick; tick;
      drive(1'b0, 4'b0000, DX, DY, DC, 1'b0);
      reset_n = 1'b1;
      tick;

      for (int i = 0; i < 14; i++) begin
         drive(1'b0, v[i].valid, v[i].sx, v[i].sy, v[i].sc, v[i].ordy);
         #1;
         check($sformatf("vec%0d_ready", i), src_ready, v[i].e_ready);
         tick;
         check($sformatf("vec%0d_plot", i), vga_plot, v[i].e_plot);
         check($sformatf("vec%0d_x", i), vga_x, v[i].e_x);
         check($sformatf("vec%0d_y", i), vga_y, v[i].e_y);
         check($sformatf("vec%0d_colour", i), vga_colour, v[i].e_c);
         check($sformatf("vec%0d_fill", i), fill, v[i].e_fill);
      end

      // Full: source 1 alone for 10 cycles with no pops; pixel k carries x=k.
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 4'b0010, {14'd0, 7'(k), 7'd0}, 28'd0, 12'd0, 1'b0);
         #1;
         check($sformatf("full_ready_%0d", k), src_ready, (k < 8) ? 4'b0010 : 4'b0000);
         tick;
      end
      check("full_fill", fill, 4'd8);
      check("full_head", vga_x, 7'd0);
      drive(1'b0, 4'b0010, {14'd0, 7'd99, 7'd0}, 28'd0, 12'd0, 1'b1);
      #1;
      check("full_pop_ready", src_ready, 4'b0000);
      tick;
      check("full_pop_fill", fill, 4'd7);
      check("full_pop_head", vga_x, 7'd1);
      drive(1'b0, 4'b0010, {14'd0, 7'd50, 7'd0}, 28'd0, 12'd0, 1'b0);
      #1;
      check("refill_ready", src_ready, 4'b0010);
      tick;
      check("refill_fill", fill, 4'd8);
      drive(1'b0, 4'b0000, 28'd0, 28'd0, 12'd0, 1'b1);
      for (int j = 0; j < 8; j++) begin
         check($sformatf("drain_x_%0d", j), vga_x, (j < 7) ? 7'(j + 1) : 7'd50);
         tick;
      end
      check("drain_fill", fill, 4'd0);
      check("drain_plot", vga_plot, 1'b0);

      // Flush: five pixels from source 0 (pointer ends at 1), then flush.
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 4'b0001, {21'd0, 7'(30 + k)}, 28'd0, 12'd0, 1'b0);
         tick;
      end
      check("preflush_fill", fill, 4'd5);
      check("preflush_head", vga_x, 7'd30);
      drive(1'b1, 4'b0100, DX, DY, DC, 1'b1);
      #1;
      check("flush_ready", src_ready, 4'b0000);
      tick;
      check("flush_fill", fill, 4'd0);
      check("flush_plot", vga_plot, 1'b0);
      check("flush_x", vga_x, 7'd0);
      drive(1'b0, 4'b1111, DX, DY, DC, 1'b0);
      #1;
      check("postflush_ready", src_ready, 4'b0001);
      tick;
      check("postflush_head", vga_x, 7'd10);

      // Async reset between edges with fill=3.
      tick; tick;
      check("prereset_fill", fill, 4'd3);
      drive(1'b0, 4'b0000, DX, DY, DC, 1'b0);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_plot", vga_plot, 1'b0);
      check("async_fill", fill, 4'd0);
      check("async_x", vga_x, 7'd0);
      tick;
      reset_n = 1'b1;
      tick;
      check("postreset_fill", fill, 4'd0);

      // Off-screen pixel x=127,y=120 from source 0.
      drive(1'b0, 4'b0001, {21'd0, 7'd127}, {21'd0, 7'd120}, 12'd5, 1'b0);
      #1;
      check("clip_ready", src_ready, 4'b0001);
      tick;
`ifdef CLIP_EN
      check("clip_fill", fill, 4'd0);
      check("clip_plot", vga_plot, 1'b0);
      check("clip_count_1", clip_count, 8'd1);
      for (int k = 0; k < 299; k++) tick;
      check("clip_sat", clip_count, 8'd255);
      check("clip_sat_fill", fill, 4'd0);
      drive(1'b0, 4'b0001, {21'd0, 7'd127}, {21'd0, 7'd119}, 12'd5, 1'b0);
      tick;
      check("edge_fill", fill, 4'd1);
      check("edge_y", vga_y, 7'd119);
      check("edge_clip", clip_count, 8'd255);
`else
      check("noclip_fill", fill, 4'd1);
      check("noclip_x", vga_x, 7'd127);
      check("noclip_y", vga_y, 7'd120);
      check("noclip_count", clip_count, 8'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
